// File: rtl/stack_reg_file.sv
// stack_reg_file: LIFO operand store with TOS/NOS taps, occupancy and sticky errors
module stack_reg_file #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] top_data,
  output logic [WIDTH-1:0] next_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] cidx, tidx, nidx, widx;
  logic             inc, dec, we, ovf_set, unf_set;
  // decode indices, operation and error events from registered state
  always_comb begin
    cidx      = IDX_W'(count);
    tidx      = cidx - IDX_W'(1);
    nidx      = cidx - IDX_W'(2);
    empty     = count == '0;
    full      = count == CNT_W'(DEPTH);
    top_data  = empty ? '0 : mem[tidx];
    next_data = (count < CNT_W'(2)) ? '0 : mem[nidx];
    inc       = push && (pop ? empty : !full);
    dec       = pop && !push && !empty;
    we        = push && !(full && !pop);
    widx      = (pop && !empty) ? tidx : cidx;
    ovf_set   = push && !pop && full;
    unf_set   = pop && empty;
  end
  // stack pointer and sticky error flags; a new error beats clr_err
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= inc ? count + CNT_W'(1) : dec ? count - CNT_W'(1) : count;
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end
  // storage write; contents are left alone on reset
  always_ff @(posedge clk) begin
    if (!reset && we) mem[widx] <= w_data;
  end
endmodule

// File: tb/tb_stack_reg_file.sv
// tb_stack_reg_file: scoreboard bench driving directed stack operations
module tb_stack_reg_file;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  typedef struct {
    string            name;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
    logic [CNT_W-1:0] cnt;
    logic             emp;
    logic             ful;
    logic             ovf;
    logic             unf;
  } exp_t;
  logic             clk = 1'b0;
  logic             reset, push, pop, clr_err;
  logic [WIDTH-1:0] w_data, top_data, next_data;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow, underflow;
  exp_t             sb [$];
  int               passed = 0;
  int               total = 0;
  bit               done = 1'b0;
  stack_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clr_err(clr_err),
    .w_data(w_data), .top_data(top_data), .next_data(next_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
  endtask
  // monitor: compares DUT state against the oldest expectation, away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "top", 32'(top_data), 32'(e.top));
        chk(e.name, "next", 32'(next_data), 32'(e.nxt));
        chk(e.name, "count", 32'(count), 32'(e.cnt));
        chk(e.name, "empty", 32'(empty), 32'(e.emp));
        chk(e.name, "full", 32'(full), 32'(e.ful));
        chk(e.name, "overflow", 32'(overflow), 32'(e.ovf));
        chk(e.name, "underflow", 32'(underflow), 32'(e.unf));
      end
    end
  end
  task automatic op(input string n, input logic rs, input logic ps, input logic pp, input logic ce,
                    input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] et, input logic [WIDTH-1:0] en,
                    input int ec, input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    reset = rs; push = ps; pop = pp; clr_err = ce; w_data = d;
    @(posedge clk);
    #1;
    e.name = n; e.top = et; e.nxt = en; e.cnt = CNT_W'(ec);
    e.emp = ec == 0; e.ful = ec == DEPTH; e.ovf = eo; e.unf = eu;
    sb.push_back(e);
  endtask
  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; w_data = '0;
    //  name          rs ps pp ce data      top       next      cnt ovf unf
    op("reset",       1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    op("push1",       0, 1, 0, 0, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0);
    op("push2",       0, 1, 0, 0, 16'h0100, 16'h0100, 16'h0001, 2, 0, 0);
    op("push3",       0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0100, 3, 0, 0);
    op("push4",       0, 1, 0, 0, 16'h1234, 16'h1234, 16'hFFFF, 4, 0, 0);
    op("push_full",   0, 1, 0, 0, 16'h5555, 16'h1234, 16'hFFFF, 4, 1, 0);
    op("replace",     0, 1, 1, 0, 16'hABCD, 16'hABCD, 16'hFFFF, 4, 1, 0);
    op("clr_ovf",     0, 0, 0, 1, 16'h0000, 16'hABCD, 16'hFFFF, 4, 0, 0);
    op("pop1",        0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0100, 3, 0, 0);
    op("pop2",        0, 0, 1, 0, 16'h0000, 16'h0100, 16'h0001, 2, 0, 0);
    op("pop3",        0, 0, 1, 0, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0);
    op("pop4",        0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    op("pop_empty",   0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    op("pp_empty",    0, 1, 1, 0, 16'h00AA, 16'h00AA, 16'h0000, 1, 0, 1);
    op("pop_last",    0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    op("clr_vs_err",  0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    op("clr_unf",     0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    op("idle",        0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    op("refill1",     0, 1, 0, 0, 16'h0011, 16'h0011, 16'h0000, 1, 0, 0);
    op("refill2",     0, 1, 0, 0, 16'h0022, 16'h0022, 16'h0011, 2, 0, 0);
    op("refill3",     0, 1, 0, 0, 16'h0033, 16'h0033, 16'h0022, 3, 0, 0);
    op("reset_push",  1, 1, 0, 0, 16'h0077, 16'h0000, 16'h0000, 0, 0, 0);
    op("push_after",  0, 1, 0, 0, 16'h0042, 16'h0042, 16'h0000, 1, 0, 0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
